// File: rtl/lut_activation_scheduler.sv
// Round-robin time-shared activation LUT with linear interpolation between adjacent entries.
// Optional build macro LUT_ROUND_EN: round half up instead of flooring the interpolation.
module lut_activation_scheduler #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FRAC_W = 4,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*IN_W-1:0]   req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       lut_addr,
  input  logic [DATA_W-1:0]       lut_base,
  input  logic [DATA_W-1:0]       lut_next,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_W-1:0]       resp_data,
  output logic [ID_W-1:0]         resp_id
);

  localparam int unsigned PW = DATA_W + FRAC_W + 2;
  localparam logic [ADDR_W-1:0] TopPosAddr = ADDR_W'((1 << (ADDR_W - 1)) - 1);

  typedef enum logic [1:0] {StIdle, StLookup, StCalc, StResp} state_e;

  state_e                     state_q, state_d;
  logic [ID_W-1:0]            ptr_q, id_q, rid_q, grant_id;
  logic                       grant_found;
  logic [IN_W-1:0]            x_q;
  logic signed [DATA_W-1:0]   base_q, next_q, data_q, y;
  logic [FRAC_W-1:0]          frac_q;
  logic signed [DATA_W:0]     diff;
  logic signed [PW-1:0]       prod, prod_adj;

  // First valid requester strictly after the last one served, wrapping around.
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_found && !rst) begin
          req_ready[grant_id] = 1'b1;
          state_d             = StLookup;
        end
      end
      StLookup: state_d = StCalc;
      StCalc:   state_d = StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    diff = $signed({next_q[DATA_W-1], next_q}) - $signed({base_q[DATA_W-1], base_q});
    prod = PW'(diff) * PW'($signed({1'b0, frac_q}));
`ifdef LUT_ROUND_EN
    prod_adj = prod + PW'(1 << (FRAC_W - 1));
`else
    prod_adj = prod;
`endif
    y = base_q + DATA_W'(prod_adj >>> FRAC_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      rid_q   <= '0;
      x_q     <= '0;
      base_q  <= '0;
      next_q  <= '0;
      frac_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && grant_found) begin
        x_q   <= req_data[grant_id*IN_W +: IN_W];
        id_q  <= grant_id;
        ptr_q <= grant_id;
      end
      if (state_q == StLookup) begin
        base_q <= lut_base;
        // No interpolation across the +max/-min discontinuity.
        next_q <= (lut_addr == TopPosAddr) ? lut_base : lut_next;
        frac_q <= x_q[FRAC_W-1:0];
      end
      if (state_q == StCalc) begin
        data_q <= y;
        rid_q  <= id_q;
      end
    end
  end

  assign lut_addr   = x_q[IN_W-1 -: ADDR_W];
  assign resp_valid = (state_q == StResp);
  assign resp_data  = data_q;
  assign resp_id    = rid_q;

endmodule
